store_writer: RTL and testbench

Commit-side store engine. It sits directly downstream of the reorder buffer's store-commit port. It accepts one committed SB/SH/SW at a time, obtains the shared byte-wide memory bus from the memory arbiter, and writes 1/2/4 bytes little-endian. It reports acceptance (`begin_real_store`) and completion (`finish_store`) back to the ROB, which holds its head until completion.

---
 rtl/store_writer.sv | 183 ++++++++++++++++++
 tb/tb_store_writer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_writer.sv
// Commit-side store engine: writes a committed SB/SH/SW to the byte-wide memory bus.
// Optional IO back-pressure on io_buffer_full is enabled by defining STORE_IO_STALL_EN.
`timescale 1ns/1ps

module store_writer #(
  parameter logic [1:0] IO_BASE_HI = 2'b11,
  parameter logic [5:0] OP_SB      = 6'd25,
  parameter logic [5:0] OP_SH      = 6'd26,
  parameter logic [5:0] OP_SW      = 6'd27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_store_sgn,
  input  logic [5:0]  rob_store_op,
  input  logic [31:0] rob_store_addr,
  input  logic [31:0] rob_store_data,
  output logic        begin_real_store,
  output logic        finish_store,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = 8;
  localparam int unsigned OPW   = 6;
  localparam int unsigned IDX_W = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;

  logic             brs_q, brs_d;
  logic             fin_q, fin_d;
  logic             req_q, req_d;
  logic             wr_q, wr_d;
  logic [AW-1:0]    a_q, a_d;
  logic [BW-1:0]    dout_q, dout_d;

  logic [IDX_W-1:0] last_c;
  logic [IDX_W-1:0] nidx_c;
  logic             stall_c;

  // Index of the final byte for the latched opcode; unknown ops store one byte
  always_comb begin
    last_c = IDX_W'(0);
    if (op_q == OP_SW) begin
      last_c = IDX_W'(3);
    end else if (op_q == OP_SH) begin
      last_c = IDX_W'(1);
    end
  end

`ifdef STORE_IO_STALL_EN
  assign stall_c = (addr_q[17:16] == IO_BASE_HI) && io_buffer_full;
`else
  logic unused_io_c;
  assign stall_c     = 1'b0;
  assign unused_io_c = ^{io_buffer_full, IO_BASE_HI};
`endif

  // Outputs are computed for the next cycle so every bus signal comes from a flop
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    brs_d   = 1'b0;
    fin_d   = 1'b0;
    req_d   = 1'b0;
    wr_d    = 1'b0;
    a_d     = '0;
    dout_d  = '0;
    nidx_c  = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (rob_store_sgn) begin
          op_d    = rob_store_op;
          addr_d  = rob_store_addr;
          data_d  = rob_store_data;
          idx_d   = '0;
          brs_d   = 1'b1;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        req_d = 1'b1;
        if (mem_gnt) begin
          state_d = ST_WRITE;
          idx_d   = '0;
          wr_d    = !stall_c;
          a_d     = addr_q;
          dout_d  = BW'(data_q);
        end
      end

      ST_WRITE: begin
        req_d = 1'b1;
        if (wr_q && (idx_q == last_c)) begin
          state_d = ST_DONE;
          fin_d   = 1'b1;
          req_d   = 1'b0;
        end else begin
          // A stalled byte keeps its index and is re-presented
          nidx_c = wr_q ? idx_q + IDX_W'(1) : idx_q;
          idx_d  = nidx_c;
          wr_d   = !stall_c;
          a_d    = addr_q + AW'(nidx_c);
          dout_d = BW'(data_q >> {nidx_c, 3'b000});
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  // Latched request, byte index and registered bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      op_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
      brs_q  <= 1'b0;
      fin_q  <= 1'b0;
      req_q  <= 1'b0;
      wr_q   <= 1'b0;
      a_q    <= '0;
      dout_q <= '0;
    end else if (rdy) begin
      idx_q  <= idx_d;
      op_q   <= op_d;
      addr_q <= addr_d;
      data_q <= data_d;
      brs_q  <= brs_d;
      fin_q  <= fin_d;
      req_q  <= req_d;
      wr_q   <= wr_d;
      a_q    <= a_d;
      dout_q <= dout_d;
    end
  end

  assign begin_real_store = brs_q;
  assign finish_store     = fin_q;
  assign mem_req          = req_q;
  assign mem_a            = a_q;
  assign mem_dout         = dout_q;
  // Strobe is gated so a frozen cycle never writes
  assign mem_wr           = wr_q & rdy;

endmodule

// File: tb/tb_store_writer.sv
// Directed self-checking bench for store_writer; outputs sampled on the falling edge.
`timescale 1ns/1ps

module tb_store_writer;

  localparam logic [5:0] OP_SB = 6'd25;
  localparam logic [5:0] OP_SH = 6'd26;
  localparam logic [5:0] OP_SW = 6'd27;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        sgn;
  logic [5:0]  op;
  logic [31:0] addr;
  logic [31:0] data;
  logic        brs;
  logic        fin;
  logic        req;
  logic        gnt;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        full;

  int n_run   = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int brs_cnt = 0;
  int fin_cnt = 0;

  store_writer #(
    .IO_BASE_HI(2'b11),
    .OP_SB(OP_SB),
    .OP_SH(OP_SH),
    .OP_SW(OP_SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .rob_store_sgn(sgn),
    .rob_store_op(op),
    .rob_store_addr(addr),
    .rob_store_data(data),
    .begin_real_store(brs),
    .finish_store(fin),
    .mem_req(req),
    .mem_gnt(gnt),
    .mem_a(mem_a),
    .mem_dout(mem_dout),
    .mem_wr(mem_wr),
    .io_buffer_full(full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (brs && rdy) brs_cnt++;
    if (fin && rdy) fin_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [31:0] a, input logic [7:0] d);
    chk({tag, ":wr"}, 32'(mem_wr), 32'd1);
    chk({tag, ":a"}, mem_a, a);
    chk({tag, ":d"}, 32'(mem_dout), 32'(d));
    chk({tag, ":req"}, 32'(req), 32'd1);
  endtask

  // Full store with an optional grant delay; lat is cycles from request edge to finish_store
  task automatic store_seq(input string tag, input logic [5:0] o, input logic [31:0] a,
                           input logic [31:0] d, input int dly, input int nb, input int lat);
    int c0;
    c0   = cyc;
    sgn  = 1'b1;
    op   = o;
    addr = a;
    data = d;
    gnt  = (dly == 0);
    @(negedge clk);
    chk({tag, ":brs"}, 32'(brs), 32'd1);
    chk({tag, ":req1"}, 32'(req), 32'd1);
    chk({tag, ":nowr"}, 32'(mem_wr), 32'd0);
    sgn = 1'b0;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk({tag, ":wait_wr"}, 32'(mem_wr), 32'd0);
      chk({tag, ":wait_req"}, 32'(req), 32'd1);
    end
    gnt = 1'b1;
    for (int j = 0; j < nb; j++) begin
      @(negedge clk);
      chk({tag, ":brs_low"}, 32'(brs), 32'd0);
      chk_wr(tag, a + 32'(j), d[8*j +: 8]);
    end
    @(negedge clk);
    chk({tag, ":fin"}, 32'(fin), 32'd1);
    chk({tag, ":req_drop"}, 32'(req), 32'd0);
    chk({tag, ":wr_drop"}, 32'(mem_wr), 32'd0);
    chk({tag, ":a_zero"}, mem_a, 32'd0);
    chk({tag, ":latency"}, 32'(cyc - c0), 32'(lat));
    gnt = 1'b0;
    @(negedge clk);
    chk({tag, ":fin_low"}, 32'(fin), 32'd0);
  endtask

  initial begin
    int b0;
    int f0;
    rst  = 1'b1;
    rdy  = 1'b1;
    sgn  = 1'b0;
    op   = '0;
    addr = '0;
    data = '0;
    gnt  = 1'b0;
    full = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst:brs", 32'(brs), 32'd0);
    chk("rst:fin", 32'(fin), 32'd0);
    chk("rst:req", 32'(req), 32'd0);
    chk("rst:wr", 32'(mem_wr), 32'd0);
    chk("rst:a", mem_a, 32'd0);
    chk("rst:d", 32'(mem_dout), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic stores: finish at T+2+N plus grant delay
    store_seq("sw", OP_SW, 32'h0000_0100, 32'hDEAD_BEEF, 0, 4, 6);
    store_seq("sh_dly", OP_SH, 32'h0000_0201, 32'h0000_ABCD, 3, 2, 7);
    store_seq("sb", OP_SB, 32'h0000_0007, 32'h1234_5678, 0, 1, 3);
    store_seq("wrap", OP_SW, 32'hFFFF_FFFE, 32'h1122_3344, 0, 4, 6);
    store_seq("op_other", 6'd5, 32'h0000_0080, 32'hCAFE_F00D, 0, 1, 3);

    // Explicit wrap bytes
    sgn = 1'b1; op = OP_SW; addr = 32'hFFFF_FFFF; data = 32'hA1B2_C3D4; gnt = 1'b1;
    @(negedge clk); sgn = 1'b0;
    @(negedge clk); chk_wr("wrap2_0", 32'hFFFF_FFFF, 8'hD4);
    @(negedge clk); chk_wr("wrap2_1", 32'h0000_0000, 8'hC3);
    @(negedge clk); chk_wr("wrap2_2", 32'h0000_0001, 8'hB2);
    @(negedge clk); chk_wr("wrap2_3", 32'h0000_0002, 8'hA1);
    @(negedge clk); chk("wrap2:fin", 32'(fin), 32'd1); gnt = 1'b0;
    @(negedge clk);

    // IO region store with the UART buffer full
    sgn = 1'b1; op = OP_SB; addr = 32'h0003_0000; data = 32'h0000_0041; gnt = 1'b1;
    @(negedge clk);
    chk("io:brs", 32'(brs), 32'd1);
    sgn  = 1'b0;
    full = 1'b1;
`ifdef STORE_IO_STALL_EN
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("io:stall_wr", 32'(mem_wr), 32'd0);
      chk("io:stall_req", 32'(req), 32'd1);
      chk("io:stall_fin", 32'(fin), 32'd0);
      if (k == 3) full = 1'b0;
    end
    @(negedge clk); chk_wr("io", 32'h0003_0000, 8'h41);
`else
    @(negedge clk); chk_wr("io", 32'h0003_0000, 8'h41);
    full = 1'b0;
`endif
    @(negedge clk); chk("io:fin", 32'(fin), 32'd1); gnt = 1'b0;
    @(negedge clk);

    // rdy low for two cycles mid-store
    sgn = 1'b1; op = OP_SW; addr = 32'h0000_0400; data = 32'h0102_0304; gnt = 1'b1;
    @(negedge clk); sgn = 1'b0;
    @(negedge clk); chk_wr("rdy_b0", 32'h0000_0400, 8'h04);
    @(posedge clk); #1 rdy = 1'b0;
    @(negedge clk);
    chk("rdy:pause1_wr", 32'(mem_wr), 32'd0);
    chk("rdy:pause1_req", 32'(req), 32'd1);
    @(negedge clk);
    chk("rdy:pause2_wr", 32'(mem_wr), 32'd0);
    @(posedge clk); #1 rdy = 1'b1;
    @(negedge clk); chk_wr("rdy_b1", 32'h0000_0401, 8'h03);
    @(negedge clk); chk_wr("rdy_b2", 32'h0000_0402, 8'h02);
    @(negedge clk); chk_wr("rdy_b3", 32'h0000_0403, 8'h01);
    @(negedge clk); chk("rdy:fin", 32'(fin), 32'd1); gnt = 1'b0;
    @(negedge clk);

    // Back-to-back with rob_store_sgn re-raised while the first store runs
    b0 = brs_cnt;
    f0 = fin_cnt;
    gnt = 1'b1;
    sgn = 1'b1; op = OP_SH; addr = 32'h0000_0600; data = 32'h0000_5A6B;
    @(negedge clk); chk("b2b:brs_a", 32'(brs), 32'd1); sgn = 1'b0;
    @(negedge clk); chk_wr("b2b_a0", 32'h0000_0600, 8'h6B);
    sgn = 1'b1; op = OP_SB; addr = 32'h0000_0700; data = 32'h0000_0099;
    @(negedge clk); chk_wr("b2b_a1", 32'h0000_0601, 8'h5A);
    @(negedge clk); chk("b2b:fin_a", 32'(fin), 32'd1); chk("b2b:done_brs", 32'(brs), 32'd0);
    @(negedge clk); chk("b2b:idle_wr", 32'(mem_wr), 32'd0); chk("b2b:idle_brs", 32'(brs), 32'd0);
    @(negedge clk); chk("b2b:brs_b", 32'(brs), 32'd1); sgn = 1'b0;
    @(negedge clk); chk_wr("b2b_b0", 32'h0000_0700, 8'h99);
    @(negedge clk); chk("b2b:fin_b", 32'(fin), 32'd1); gnt = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b:brs_count", 32'(brs_cnt - b0), 32'd2);
    chk("b2b:fin_count", 32'(fin_cnt - f0), 32'd2);

    // Asynchronous reset mid-store
    f0 = fin_cnt;
    sgn = 1'b1; op = OP_SW; addr = 32'h0000_0500; data = 32'hA5A5_5A5A; gnt = 1'b1;
    @(negedge clk); sgn = 1'b0;
    @(negedge clk); chk_wr("ar_b0", 32'h0000_0500, 8'h5A);
    @(negedge clk); chk_wr("ar_b1", 32'h0000_0501, 8'h5A);
    #2 rst = 1'b1;
    #1;
    chk("ar:wr", 32'(mem_wr), 32'd0);
    chk("ar:req", 32'(req), 32'd0);
    chk("ar:a", mem_a, 32'd0);
    chk("ar:d", 32'(mem_dout), 32'd0);
    gnt = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("ar:no_fin", 32'(fin_cnt - f0), 32'd0);
    chk("ar:idle_req", 32'(req), 32'd0);
    store_seq("post_rst", OP_SB, 32'h0000_0010, 32'h0000_0077, 0, 1, 3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
